link_frame_tx: RTL and testbench

- Credit-based frame transmitter for the user side of a simulation link endpoint's transmit path.
- Accepts message descriptors (channel, length) plus a payload word stream.
- Serialises each message as one header word followed by payload words into the endpoint's tx enqueue interface.
- Consumes credit-return words from the endpoint's rx dequeue interface. This is the transmit-side counterpart of the link's receive/deframe path.

---
 rtl/link_frame_tx_if.sv | 30 +++
 rtl/link_frame_tx.sv | 126 ++++++++++++
 tb/tb_link_frame_tx.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/link_frame_tx_if.sv
// link_frame_tx_if: descriptor, payload, link tx-enqueue and link rx-dequeue signals of the frame transmitter
interface link_frame_tx_if #(
    parameter int DATAWIDTH = 32
);
    logic                 msg_valid;
    logic [7:0]           msg_chan;
    logic [15:0]          msg_len;
    logic                 msg_ready;
    logic                 data_valid;
    logic [DATAWIDTH-1:0] data_v;
    logic                 data_ready;
    logic [DATAWIDTH-1:0] link_tx_v;
    logic                 en_link_tx_enq;
    logic                 rdy_link_tx_enq;
    logic [DATAWIDTH-1:0] link_rx_first;
    logic                 rdy_link_rx_first;
    logic                 en_link_rx_deq;

    modport master (
        output msg_valid, msg_chan, msg_len, data_valid, data_v,
        output rdy_link_tx_enq, link_rx_first, rdy_link_rx_first,
        input  msg_ready, data_ready, link_tx_v, en_link_tx_enq, en_link_rx_deq
    );

    modport slave (
        input  msg_valid, msg_chan, msg_len, data_valid, data_v,
        input  rdy_link_tx_enq, link_rx_first, rdy_link_rx_first,
        output msg_ready, data_ready, link_tx_v, en_link_tx_enq, en_link_rx_deq
    );
endinterface

// File: rtl/link_frame_tx.sv
// link_frame_tx: credit-gated header+payload framer; LINK_FRAME_TRAILER_EN adds an XOR trailer word per frame
module link_frame_tx #(
    parameter int DATAWIDTH    = 32,
    parameter int CREDITS_INIT = 8
) (
    input  logic                CLK,
    input  logic                RST,
    link_frame_tx_if.slave      bus,
    input  logic                link_up,
    output logic [15:0]         credits,
    output logic                busy,
    output logic [31:0]         frames_sent,
    output logic                err_bad_rx
);
    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAYLOAD
`ifdef LINK_FRAME_TRAILER_EN
        , TRAILER
`endif
    } state_t;

    state_t               state;
    logic [7:0]           chan;
    logic [15:0]          len;
    logic [15:0]          remaining;
    logic [DATAWIDTH-1:0] hdr_word;
    logic                 gate;
    logic                 accept;
    logic                 enq;
    logic                 is_credit;
    logic [15:0]          ret_amt;
    logic [16:0]          sum;
    logic                 unused_rx;
`ifdef LINK_FRAME_TRAILER_EN
    logic [DATAWIDTH-1:0] acc;
`endif

    // Handshake strobes are combinational on registered state/credits and forced low during reset
    always_comb begin
        hdr_word           = DATAWIDTH'({chan, 8'h00, len});
        gate               = bus.rdy_link_tx_enq && credits != 16'd0;
        bus.msg_ready      = !RST && link_up && state == IDLE;
        accept             = bus.msg_valid && bus.msg_ready;
        bus.data_ready     = !RST && state == PAYLOAD && gate;
`ifdef LINK_FRAME_TRAILER_EN
        enq                = !RST && (state == PAYLOAD ? bus.data_valid && gate : state != IDLE && gate);
        bus.link_tx_v      = state == PAYLOAD ? bus.data_v : state == TRAILER ? acc : hdr_word;
`else
        enq                = !RST && (state == PAYLOAD ? bus.data_valid && gate : state == HDR && gate);
        bus.link_tx_v      = state == PAYLOAD ? bus.data_v : hdr_word;
`endif
        bus.en_link_tx_enq = enq;
        bus.en_link_rx_deq = !RST && bus.rdy_link_rx_first;
        is_credit          = bus.link_rx_first[31:24] == 8'hC0;
        ret_amt            = bus.en_link_rx_deq && is_credit ? bus.link_rx_first[15:0] : 16'd0;
        sum                = {1'b0, credits} + {1'b0, ret_amt} - 17'(enq);
        busy               = state != IDLE;
        unused_rx          = ^bus.link_rx_first;
    end

    // Frame sequencing, credit accounting (saturating) and rx error flag
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            credits     <= 16'(CREDITS_INIT);
            frames_sent <= '0;
            remaining   <= '0;
            err_bad_rx  <= 1'b0;
            chan        <= '0;
            len         <= '0;
`ifdef LINK_FRAME_TRAILER_EN
            acc         <= '0;
`endif
        end else begin
            credits    <= sum[16] ? 16'hFFFF : sum[15:0];
            err_bad_rx <= bus.en_link_rx_deq && !is_credit;
            case (state)
                IDLE: if (accept) begin
                    chan  <= bus.msg_chan;
                    len   <= bus.msg_len;
                    state <= HDR;
`ifdef LINK_FRAME_TRAILER_EN
                    acc   <= '0;
`endif
                end
                HDR: if (enq) begin
`ifdef LINK_FRAME_TRAILER_EN
                    acc <= acc ^ hdr_word;
`endif
                    if (len == 16'd0) begin
`ifdef LINK_FRAME_TRAILER_EN
                        state <= TRAILER;
`else
                        state       <= IDLE;
                        frames_sent <= frames_sent + 32'd1;
`endif
                    end else begin
                        remaining <= len;
                        state     <= PAYLOAD;
                    end
                end
                PAYLOAD: if (enq) begin
                    remaining <= remaining - 16'd1;
`ifdef LINK_FRAME_TRAILER_EN
                    acc <= acc ^ bus.data_v;
                    if (remaining == 16'd1) state <= TRAILER;
`else
                    if (remaining == 16'd1) begin
                        state       <= IDLE;
                        frames_sent <= frames_sent + 32'd1;
                    end
`endif
                end
`ifdef LINK_FRAME_TRAILER_EN
                TRAILER: if (enq) begin
                    state       <= IDLE;
                    frames_sent <= frames_sent + 32'd1;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_link_frame_tx.sv
// tb_link_frame_tx: directed frames with a scoreboard monitor checking every enqueued link word
module tb_link_frame_tx;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        link_up = 1'b1;
    logic [15:0] credits;
    logic        busy;
    logic [31:0] frames_sent;
    logic        err_bad_rx;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          feed_fire;
    logic [31:0] exp_q[$];
    logic [31:0] pay_q[$];
    logic [31:0] pend_q[$];

    link_frame_tx_if #(.DATAWIDTH(32)) bus ();

    link_frame_tx #(.DATAWIDTH(32), .CREDITS_INIT(8)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus),
        .link_up(link_up),
        .credits(credits),
        .busy(busy),
        .frames_sent(frames_sent),
        .err_bad_rx(err_bad_rx)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every enqueued word must match the next scoreboard entry
    always @(negedge CLK) begin
        if (bus.en_link_tx_enq === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_enq: got 0x%08h expected no word", bus.link_tx_v);
            end else begin
                chk("enq_word", bus.link_tx_v, exp_q.pop_front());
            end
        end
    end

    // Payload source: presents pay_q head, pops after each accepted word
    initial begin
        bus.data_valid = 1'b0;
        bus.data_v     = '0;
        forever begin
            @(negedge CLK);
            feed_fire = bus.data_valid && bus.data_ready;
            @(posedge CLK);
            #1;
            if (feed_fire && pay_q.size() > 0) void'(pay_q.pop_front());
            bus.data_valid = pay_q.size() > 0;
            bus.data_v     = pay_q.size() > 0 ? pay_q[0] : 32'h0;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pay(input logic [31:0] w);
        pay_q.push_back(w);
        pend_q.push_back(w);
    endtask

    task automatic send_msg(input logic [7:0] c, input logic [15:0] l);
        bit done = 1'b0;
        exp_q.push_back({c, 8'h00, l});
        while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
        bus.msg_chan  = c;
        bus.msg_len   = l;
        bus.msg_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge CLK);
            done = bus.msg_ready;
            tick();
        end
        bus.msg_valid = 1'b0;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL msg_accept: got no accept expected accept within 50 cycles");
        end
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int i = 0; i < 100 && !idle; i++) begin
            @(negedge CLK);
            idle = !busy;
        end
        if (!idle) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_wait: got busy expected idle within 100 cycles");
        end
    endtask

    task automatic rx_word(input logic [31:0] w);
        tick();
        bus.link_rx_first     = w;
        bus.rdy_link_rx_first = 1'b1;
        tick();
        bus.rdy_link_rx_first = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1);
    end

    initial begin
        bus.msg_valid         = 1'b0;
        bus.msg_chan          = '0;
        bus.msg_len           = '0;
        bus.rdy_link_tx_enq   = 1'b1;
        bus.link_rx_first     = 32'h12345678;
        bus.rdy_link_rx_first = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst_credits", 32'(credits), 32'd8);
        chk("rst_frames", frames_sent, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_msg_ready", 32'(bus.msg_ready), 32'd0);
        chk("rst_enq", 32'(bus.en_link_tx_enq), 32'd0);
        chk("rst_deq", 32'(bus.en_link_rx_deq), 32'd0);
        chk("rst_err", 32'(err_bad_rx), 32'd0);
        bus.rdy_link_rx_first = 1'b0;
        tick();
        RST = 1'b0;
        tick();
        // Single frame, back-to-back words
        pay(32'h11111111);
        pay(32'h22222222);
        send_msg(8'd3, 16'd2);
        repeat (3) begin
            @(negedge CLK);
            chk("t1_consec_enq", 32'(bus.en_link_tx_enq), 32'd1);
        end
        @(negedge CLK);
        chk("t1_credits", 32'(credits), 32'd5);
        chk("t1_frames", frames_sent, 32'd1);
        chk("t1_busy", 32'(busy), 32'd0);
        // Header-only frame
        tick();
        send_msg(8'h5A, 16'd0);
        @(negedge CLK);
        chk("hdr_only_enq", 32'(bus.en_link_tx_enq), 32'd1);
        @(negedge CLK);
        chk("hdr_only_msg_ready", 32'(bus.msg_ready), 32'd1);
        chk("hdr_only_frames", frames_sent, 32'd2);
        chk("hdr_only_credits", 32'(credits), 32'd4);
        // Drain to a single credit
        tick();
        pay(32'h000000A0);
        pay(32'h000000A1);
        send_msg(8'd4, 16'd2);
        wait_idle();
        chk("drain_credits", 32'(credits), 32'd1);
        // Credit stall then release
        tick();
        pay(32'h000000B0);
        send_msg(8'd7, 16'd1);
        @(negedge CLK);
        chk("stall_hdr_enq", 32'(bus.en_link_tx_enq), 32'd1);
        repeat (5) begin
            @(negedge CLK);
            chk("stall_data_ready", 32'(bus.data_ready), 32'd0);
        end
        chk("stall_credits", 32'(credits), 32'd0);
        tick();
        bus.link_rx_first     = 32'hC0000004;
        bus.rdy_link_rx_first = 1'b1;
        @(negedge CLK);
        chk("stall_deq", 32'(bus.en_link_rx_deq), 32'd1);
        chk("stall_same_cycle_enq", 32'(bus.en_link_tx_enq), 32'd0);
        tick();
        bus.rdy_link_rx_first = 1'b0;
        @(negedge CLK);
        chk("stall_release_enq", 32'(bus.en_link_tx_enq), 32'd1);
        chk("stall_release_credits", 32'(credits), 32'd4);
        @(negedge CLK);
        chk("stall_final_credits", 32'(credits), 32'd3);
        chk("stall_frames", frames_sent, 32'd4);
        // Credit return coincident with the last payload enq
        tick();
        pay(32'h000000C0);
        pay(32'h000000C1);
        send_msg(8'd9, 16'd2);
        tick();
        tick();
        bus.link_rx_first     = 32'hC0000002;
        bus.rdy_link_rx_first = 1'b1;
        @(negedge CLK);
        chk("simul_enq", 32'(bus.en_link_tx_enq), 32'd1);
        chk("simul_pre_credits", 32'(credits), 32'd1);
        tick();
        bus.rdy_link_rx_first = 1'b0;
        @(negedge CLK);
        chk("simul_credits", 32'(credits), 32'd2);
        chk("simul_frames", frames_sent, 32'd5);
        // Non-credit rx word
        tick();
        bus.link_rx_first     = 32'h12345678;
        bus.rdy_link_rx_first = 1'b1;
        @(negedge CLK);
        chk("bad_rx_deq", 32'(bus.en_link_rx_deq), 32'd1);
        chk("bad_rx_err_early", 32'(err_bad_rx), 32'd0);
        tick();
        bus.rdy_link_rx_first = 1'b0;
        @(negedge CLK);
        chk("bad_rx_err_pulse", 32'(err_bad_rx), 32'd1);
        chk("bad_rx_credits", 32'(credits), 32'd2);
        @(negedge CLK);
        chk("bad_rx_err_end", 32'(err_bad_rx), 32'd0);
        // Saturation, ignoring bits 23:16 of the return word
        rx_word(32'hC000FFFC);
        @(negedge CLK);
        chk("sat_65534", 32'(credits), 32'd65534);
        rx_word(32'hC07F0010);
        @(negedge CLK);
        chk("sat_65535", 32'(credits), 32'd65535);
        // Reset in the middle of a payload
        tick();
        pay(32'h000000D0);
        send_msg(8'd1, 16'd3);
        repeat (3) @(negedge CLK);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        tick();
        RST = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_enq", 32'(bus.en_link_tx_enq), 32'd0);
        chk("mid_rst_credits", 32'(credits), 32'd8);
        chk("mid_rst_frames", frames_sent, 32'd0);
        chk("mid_rst_data_ready", 32'(bus.data_ready), 32'd0);
        chk("mid_rst_sb_empty", 32'(exp_q.size()), 32'd0);
        tick();
        RST = 1'b0;
        // Link drop mid-frame completes the frame but blocks new descriptors
        tick();
        pay(32'h000000E0);
        send_msg(8'h22, 16'd1);
        link_up = 1'b0;
        wait_idle();
        chk("linkdown_frames", frames_sent, 32'd1);
        chk("linkdown_credits", 32'(credits), 32'd6);
        chk("linkdown_msg_ready", 32'(bus.msg_ready), 32'd0);
        link_up = 1'b1;
        repeat (3) @(negedge CLK);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
